// File: rtl/fl.sv
// Free list of physical register tags for a 2-wide rename stage; circular buffer with recover-to-retired-head.
// Optional sticky protocol checking is built only when FL_CHECK_EN is defined.
module fl #(
  parameter int FL_DEPTH = 96,
  parameter int PR_BASE  = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] id_dispatch_num,
  input  logic [1:0] rob_retire_num,
  input  logic [6:0] rob_retire_told0,
  input  logic [6:0] rob_retire_told1,
  input  logic       recover,
  output logic [6:0] fl_pr0,
  output logic [6:0] fl_pr1,
  output logic [1:0] fl_free_num,
  output logic       fl_empty,
  output logic       fl_error
);

  logic [6:0] r_mem [0:FL_DEPTH-1];
  logic [6:0] r_head;
  logic [6:0] r_tail;
  logic [6:0] r_retired_head;
  logic [6:0] r_count;

  logic [6:0] w_head1;
  logic [6:0] w_tail1;
  logic [1:0] w_free_num;
  logic [1:0] w_disp;
  logic [1:0] w_ret;
  logic [7:0] w_count_sum;
  logic [6:0] w_count_nxt;

  // Depth is not a power of two, so wrap by compare-and-subtract.
  function automatic logic [6:0] f_wrap_add(input logic [6:0] p, input logic [1:0] n);
    logic [7:0] s;
    s = {1'b0, p} + {6'd0, n};
    if (s >= 8'(FL_DEPTH)) s = s - 8'(FL_DEPTH);
    return s[6:0];
  endfunction

  always_comb begin
    w_head1     = f_wrap_add(r_head, 2'd1);
    w_tail1     = f_wrap_add(r_tail, 2'd1);
    w_free_num  = (r_count >= 7'd2) ? 2'd2 : r_count[1:0];
    // An over-request drops the dispatch half of the cycle; retire still lands.
    w_disp      = (id_dispatch_num <= w_free_num) ? id_dispatch_num : 2'd0;
    w_ret       = (rob_retire_num == 2'd3) ? 2'd0 : rob_retire_num;
    w_count_sum = {1'b0, r_count} + {6'd0, w_ret} - {6'd0, w_disp};
    w_count_nxt = (w_count_sum > 8'(FL_DEPTH)) ? 7'(FL_DEPTH) : w_count_sum[6:0];
  end

  assign fl_pr0      = r_mem[r_head];
  assign fl_pr1      = r_mem[w_head1];
  assign fl_free_num = w_free_num;
  assign fl_empty    = (r_count == 7'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) r_mem[i] <= 7'(PR_BASE + i);
      r_head         <= 7'd0;
      r_tail         <= 7'd0;
      r_retired_head <= 7'd0;
      r_count        <= 7'(FL_DEPTH);
    end else if (recover) begin
      // Everything between retired_head and head becomes free again.
      r_head  <= r_retired_head;
      r_count <= 7'(FL_DEPTH);
    end else begin
      if (w_ret != 2'd0) r_mem[r_tail]  <= rob_retire_told0;
      if (w_ret == 2'd2) r_mem[w_tail1] <= rob_retire_told1;
      r_head         <= f_wrap_add(r_head, w_disp);
      r_tail         <= f_wrap_add(r_tail, w_ret);
      r_retired_head <= f_wrap_add(r_retired_head, w_ret);
      r_count        <= w_count_nxt;
    end
  end

`ifdef FL_CHECK_EN
  logic r_error;
  logic w_viol;

  always_comb begin
    w_viol = (id_dispatch_num > w_free_num)
          || (({1'b0, r_count} + {6'd0, rob_retire_num}) > 8'(FL_DEPTH))
          || (id_dispatch_num == 2'd3)
          || (rob_retire_num == 2'd3);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (!recover && w_viol) begin
      r_error <= 1'b1;
      $display("fl: protocol violation at time %0t (dispatch=%0d retire=%0d count=%0d)",
               $time, id_dispatch_num, rob_retire_num, r_count);
    end
  end

  assign fl_error = r_error;
`else
  assign fl_error = 1'b0;
`endif

endmodule

// File: tb/tb_fl.sv
// Bench for fl: queue-based free/in-flight tag model plus a scoreboard of dispatched tags.
module tb_fl;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] id_dispatch_num;
  logic [1:0] rob_retire_num;
  logic [6:0] rob_retire_told0;
  logic [6:0] rob_retire_told1;
  logic       recover;
  logic [6:0] fl_pr0;
  logic [6:0] fl_pr1;
  logic [1:0] fl_free_num;
  logic       fl_empty;
  logic       fl_error;

  int errs   = 0;
  int checks = 0;

  logic [6:0] m_free [$];
  logic [6:0] m_infl [$];
  logic [6:0] sb_exp [$];
  logic [6:0] sb_act [$];
  logic       m_error;

  fl dut (
    .clock            (clk),
    .reset            (reset),
    .id_dispatch_num  (id_dispatch_num),
    .rob_retire_num   (rob_retire_num),
    .rob_retire_told0 (rob_retire_told0),
    .rob_retire_told1 (rob_retire_told1),
    .recover          (recover),
    .fl_pr0           (fl_pr0),
    .fl_pr1           (fl_pr1),
    .fl_free_num      (fl_free_num),
    .fl_empty         (fl_empty),
    .fl_error         (fl_error)
  );

  always #5 clk = ~clk;

  // Capture the tags the rename stage actually consumes.
  always @(negedge clk) begin
    if (!reset && !recover && id_dispatch_num != 2'd0 && id_dispatch_num <= fl_free_num) begin
      sb_act.push_back(fl_pr0);
      if (id_dispatch_num == 2'd2) sb_act.push_back(fl_pr1);
    end
  end

  task automatic cyc(input int d, input int r, input logic [6:0] t0, input logic [6:0] t1,
                     input logic rec);
    int avail;
    id_dispatch_num  = d[1:0];
    rob_retire_num   = r[1:0];
    rob_retire_told0 = t0;
    rob_retire_told1 = t1;
    recover          = rec;
    avail = (m_free.size() >= 2) ? 2 : m_free.size();
    if (rec) begin
      m_free = {m_infl, m_free};
      m_infl.delete();
    end else begin
      if (d <= avail) begin
        for (int i = 0; i < d; i++) begin
          m_infl.push_back(m_free[0]);
          sb_exp.push_back(m_free[0]);
          void'(m_free.pop_front());
        end
      end else begin
        m_error = 1'b1;
      end
      for (int i = 0; i < r; i++) void'(m_infl.pop_front());
      if (r >= 1) m_free.push_back(t0);
      if (r == 2) m_free.push_back(t1);
    end
    @(posedge clk); #1;
    id_dispatch_num = 2'd0;
    rob_retire_num  = 2'd0;
    recover         = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    id_dispatch_num = 2'd0; rob_retire_num = 2'd0; recover = 1'b0;
    rob_retire_told0 = 7'd0; rob_retire_told1 = 7'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_free.delete(); m_infl.delete(); sb_exp.delete(); sb_act.delete();
    for (int i = 32; i < 128; i++) m_free.push_back(7'(i));
    m_error = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc(0, 0, 7'd0, 7'd0, 1'b0);
    checks++; if (fl_pr0 !== 7'd32) begin errs++; $display("FAIL reset_pr0 got %0d want 32", fl_pr0); end
    checks++; if (fl_pr1 !== 7'd33) begin errs++; $display("FAIL reset_pr1 got %0d want 33", fl_pr1); end
    checks++; if (fl_free_num !== 2'd2) begin errs++; $display("FAIL reset_free got %0d want 2", fl_free_num); end
    checks++; if (fl_empty !== 1'b0) begin errs++; $display("FAIL reset_empty got %0b want 0", fl_empty); end
    checks++; if (fl_error !== 1'b0) begin errs++; $display("FAIL reset_error got %0b want 0", fl_error); end
    checks++; if (dut.r_count !== 7'd96) begin errs++; $display("FAIL reset_count got %0d want 96", dut.r_count); end
  endtask

  task automatic test_drain();
    logic [6:0] e, a;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      if (c == 47) begin
        checks++; if (fl_pr0 !== 7'd126) begin errs++; $display("FAIL drain_pr0 got %0d want 126", fl_pr0); end
        checks++; if (fl_pr1 !== 7'd127) begin errs++; $display("FAIL drain_pr1 got %0d want 127", fl_pr1); end
      end
      cyc(2, 0, 7'd0, 7'd0, 1'b0);
    end
    checks++; if (fl_empty !== 1'b1) begin errs++; $display("FAIL drain_empty got %0b want 1", fl_empty); end
    checks++; if (fl_free_num !== 2'd0) begin errs++; $display("FAIL drain_free got %0d want 0", fl_free_num); end
    checks++;
    if (sb_act.size() != sb_exp.size()) begin
      errs++; $display("FAIL drain_sb_size got %0d want %0d", sb_act.size(), sb_exp.size());
    end
    while (sb_exp.size() > 0 && sb_act.size() > 0) begin
      e = sb_exp.pop_front(); a = sb_act.pop_front();
      checks++; if (a !== e) begin errs++; $display("FAIL drain_tag got %0d want %0d", a, e); end
    end
  endtask

  task automatic test_refill();
    cyc(0, 2, 7'd5, 7'd9, 1'b0);
    checks++; if (fl_pr0 !== 7'd5) begin errs++; $display("FAIL refill_pr0 got %0d want 5", fl_pr0); end
    checks++; if (fl_pr1 !== 7'd9) begin errs++; $display("FAIL refill_pr1 got %0d want 9", fl_pr1); end
    checks++; if (fl_free_num !== 2'd2) begin errs++; $display("FAIL refill_free got %0d want 2", fl_free_num); end
    checks++; if (fl_empty !== 1'b0) begin errs++; $display("FAIL refill_empty got %0b want 0", fl_empty); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 47; c++) cyc(2, 0, 7'd0, 7'd0, 1'b0);
    cyc(1, 2, 7'd10, 7'd11, 1'b0);
    checks++; if (dut.r_head !== 7'd95) begin errs++; $display("FAIL wrap_head95 got %0d want 95", dut.r_head); end
    checks++; if (fl_pr0 !== 7'd127) begin errs++; $display("FAIL wrap_pr0 got %0d want 127", fl_pr0); end
    checks++; if (fl_pr1 !== 7'd10) begin errs++; $display("FAIL wrap_pr1 got %0d want 10", fl_pr1); end
    cyc(2, 0, 7'd0, 7'd0, 1'b0);
    checks++; if (dut.r_head !== 7'd1) begin errs++; $display("FAIL wrap_head1 got %0d want 1", dut.r_head); end
    checks++; if (fl_pr0 !== 7'd11) begin errs++; $display("FAIL wrap_pr0b got %0d want 11", fl_pr0); end
    checks++; if (fl_free_num !== 2'd1) begin errs++; $display("FAIL wrap_free got %0d want 1", fl_free_num); end
  endtask

  task automatic test_recover();
    do_reset();
    for (int c = 0; c < 3; c++) cyc(2, 0, 7'd0, 7'd0, 1'b0);
    cyc(0, 2, 7'd3, 7'd4, 1'b0);
    cyc(2, 2, 7'd50, 7'd51, 1'b1);
    checks++; if (fl_pr0 !== 7'd34) begin errs++; $display("FAIL recover_pr0 got %0d want 34", fl_pr0); end
    checks++; if (fl_pr1 !== m_free[1]) begin errs++; $display("FAIL recover_pr1 got %0d want %0d", fl_pr1, m_free[1]); end
    checks++; if (dut.r_count !== 7'd96) begin errs++; $display("FAIL recover_count got %0d want 96", dut.r_count); end
    checks++; if (dut.r_mem[0] !== 7'd3) begin errs++; $display("FAIL recover_mem0 got %0d want 3", dut.r_mem[0]); end
    checks++; if (dut.r_mem[1] !== 7'd4) begin errs++; $display("FAIL recover_mem1 got %0d want 4", dut.r_mem[1]); end
    checks++; if (dut.r_tail !== dut.r_retired_head) begin
      errs++; $display("FAIL recover_tail got %0d want %0d", dut.r_tail, dut.r_retired_head);
    end
  endtask

  task automatic test_back_to_back();
    int d, r, avail;
    logic rec;
    logic [6:0] e, a;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      avail = (m_free.size() >= 2) ? 2 : m_free.size();
      d   = $urandom_range(0, avail);
      r   = $urandom_range(0, (m_infl.size() >= 2) ? 2 : m_infl.size());
      rec = ($urandom_range(0, 29) == 0);
      cyc(d, r, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), rec);
      avail = (m_free.size() >= 2) ? 2 : m_free.size();
      checks++; if (fl_free_num !== 2'(avail)) begin errs++; $display("FAIL b2b_free got %0d want %0d", fl_free_num, avail); end
      checks++; if (fl_empty !== (m_free.size() == 0)) begin errs++; $display("FAIL b2b_empty got %0b want %0b", fl_empty, m_free.size() == 0); end
      if (m_free.size() >= 1) begin
        checks++; if (fl_pr0 !== m_free[0]) begin errs++; $display("FAIL b2b_pr0 got %0d want %0d", fl_pr0, m_free[0]); end
      end
      if (m_free.size() >= 2) begin
        checks++; if (fl_pr1 !== m_free[1]) begin errs++; $display("FAIL b2b_pr1 got %0d want %0d", fl_pr1, m_free[1]); end
      end
      checks++;
      if ((int'(dut.r_head) + int'(dut.r_count)) % 96 != int'(dut.r_tail)) begin
        errs++; $display("FAIL b2b_invariant head=%0d count=%0d tail=%0d", dut.r_head, dut.r_count, dut.r_tail);
      end
      while (sb_exp.size() > 0 && sb_act.size() > 0) begin
        e = sb_exp.pop_front(); a = sb_act.pop_front();
        checks++; if (a !== e) begin errs++; $display("FAIL b2b_tag got %0d want %0d", a, e); end
      end
    end
    checks++;
    if (sb_act.size() != sb_exp.size()) begin
      errs++; $display("FAIL b2b_sb_size got %0d want %0d", sb_act.size(), sb_exp.size());
    end
  endtask

  task automatic test_error();
    logic exp_err;
    do_reset();
    for (int c = 0; c < 47; c++) cyc(2, 0, 7'd0, 7'd0, 1'b0);
    cyc(1, 0, 7'd0, 7'd0, 1'b0);
    checks++; if (fl_free_num !== 2'd1) begin errs++; $display("FAIL err_free got %0d want 1", fl_free_num); end
    cyc(2, 0, 7'd0, 7'd0, 1'b0);
`ifdef FL_CHECK_EN
    exp_err = m_error;
`else
    exp_err = 1'b0;
`endif
    checks++; if (fl_error !== exp_err) begin errs++; $display("FAIL err_set got %0b want %0b", fl_error, exp_err); end
    checks++; if (dut.r_head !== 7'd95) begin errs++; $display("FAIL err_head got %0d want 95", dut.r_head); end
    checks++; if (fl_pr0 !== m_free[0]) begin errs++; $display("FAIL err_pr0 got %0d want %0d", fl_pr0, m_free[0]); end
    cyc(0, 0, 7'd0, 7'd0, 1'b0);
    checks++; if (fl_error !== exp_err) begin errs++; $display("FAIL err_sticky got %0b want %0b", fl_error, exp_err); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_refill();
    test_wrap();
    test_recover();
    test_back_to_back();
    test_error();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fl.md
Name: fl

Overview:
- Free list of physical register tags for the 2-wide rename stage.
- A circular buffer of 96 entries holds the unallocated tags out of 128 (7-bit). At reset these are tags 32..127; tags 0..31 are architectural.
- Each cycle it presents the next two free tags (fl_pr0, fl_pr1) to the map table. It pops them on dispatch and pushes retired Told tags from the ROB.
- It keeps a retired head pointer so that a branch/exception recover restores all speculatively allocated tags in one cycle.

Parameters:
- FL_DEPTH, 96, number of free-list entries (physical regs minus architectural regs).
- PR_BASE, 32, first tag loaded at reset; entry i resets to PR_BASE+i.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- id_dispatch_num  input  2  number of tags consumed this cycle (0..2); counts only instructions that allocate a destination.
- rob_retire_num  input  2  number of retiring instructions returning a Told tag (0..2).
- rob_retire_told0  input  7  Told tag of the older retiring instruction.
- rob_retire_told1  input  7  Told tag of the younger retiring instruction.
- recover  input  1  squash all speculative allocations.
- fl_pr0  output  7  tag at head.
- fl_pr1  output  7  tag at head+1 (mod FL_DEPTH).
- fl_free_num  output  2  min(count, 2); dispatch must not exceed this.
- fl_empty  output  1  count == 0.
- fl_error  output  1  sticky protocol-violation flag (see Optional Feature).

Behaviour:
- State: mem[0..95] (7b each), head, tail, retired_head (7b each, values 0..95), count (7b, 0..96).
- Reset:
  - mem[i] = 32+i; head = tail = retired_head = 0; count = 96.
  - fl_pr0 = 32, fl_pr1 = 33, fl_free_num = 2, fl_empty = 0, fl_error = 0.
  - Reset overrides recover and all other inputs.
- Outputs are combinational from registered state: fl_pr0 = mem[head], fl_pr1 = mem[(head+1) mod 96]. No input-to-output paths.
- Pointer arithmetic: every increment wraps modulo FL_DEPTH (95+1 -> 0, 95+2 -> 1). It is not power-of-two wrap; implementation must compare and subtract.
- Normal cycle (recover = 0):
  - head += id_dispatch_num.
  - retire_num >= 1: mem[tail] <= told0. retire_num == 2: mem[tail+1] <= told1.
  - tail += rob_retire_num.
  - retired_head += rob_retire_num (each retiring instruction consumed one tag at dispatch, in order).
  - count <= count + rob_retire_num - id_dispatch_num.
- Simultaneous dispatch and retire: both apply in the same cycle. Tags pushed this cycle are not visible on fl_pr0/fl_pr1 until the next cycle, so the available count is the registered count only.
- Full (count = 96): retire while full is a protocol violation; a legal ROB cannot produce it. Writes still occur, and count saturates at 96.
- Empty (count = 0): fl_free_num = 0 and fl_empty = 1. fl_pr0/fl_pr1 show stale entries and must not be used.
- Over-request: id_dispatch_num > fl_free_num is a violation. head/count are left unchanged for the dispatch part; retire still applies.
- Recover cycle:
  - head <= retired_head; count <= 96.
  - tail and mem are unchanged; dispatch and retire inputs are ignored.
  - The ROB is empty after recover, so tail == retired_head holds.
- Invariant checked by the bench: (head + count) mod 96 == tail whenever not recovering.

Optional Feature:
- Macro FL_CHECK_EN.
- Defined:
  - fl_error is set (sticky until reset) on any of: dispatch_num > fl_free_num; count + retire_num > 96; dispatch_num == 3 or retire_num == 3.
  - A $display with cycle time is issued on each violation.
- Undefined: fl_error is tied 0 and no checking logic is built. Functional behaviour is otherwise identical.

Test Plan:
- Reset then idle -> fl_pr0 = 32, fl_pr1 = 33, fl_free_num = 2, count = 96.
- Dispatch 2 per cycle for 48 cycles -> fl_empty = 1, fl_free_num = 0 after cycle 48; in cycle 47 fl_pr0 = 126, fl_pr1 = 127.
- From empty, retire 2 with told0 = 5, told1 = 9 -> next cycle fl_pr0 = 5, fl_pr1 = 9, fl_free_num = 2.
- Wrap: head = 95 with count >= 2 -> fl_pr1 = mem[0]; dispatch 2 -> head = 1.
- Dispatch 6 tags (32..37), retire 2 (told 3, 4), then recover:
  - Next cycle fl_pr0 = 34, count = 96.
  - Tags 3 and 4 reside at mem[0], mem[1].
- With FL_CHECK_EN: dispatch 2 while fl_free_num = 1 -> fl_error = 1 next cycle and remains 1; head is unchanged.
